// File: rtl/shift_result_fifo.sv
// Result FIFO behind the sign-magnitude shifter: canonicalises each result, buffers it
// with first-word fall-through, and keeps saturating ERR/ovf counters and a sticky drop flag.
module shift_result_fifo #(
   parameter int N     = 8,
   parameter int DEPTH = 4,
   parameter int CW    = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_valid,
   output logic                       o_ready,
   input  logic [N-1:0]               i_data,
   input  logic                       i_err,
   input  logic                       i_ovf,
   output logic                       o_valid,
   input  logic                       i_ready,
   output logic [N-1:0]               o_data,
   output logic                       o_err,
   output logic                       o_ovf,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [CW-1:0]              o_err_cnt,
   output logic [CW-1:0]              o_ovf_cnt,
   output logic                       o_drop,
   input  logic                       i_clr
);
   localparam int AW   = $clog2(DEPTH);
   localparam int CNTW = $clog2(DEPTH+1);
   localparam logic [N-1:0] NEG_ZERO = {1'b1, {(N-1){1'b0}}};

   typedef struct packed {
      logic [N-1:0] data;
      logic         err;
      logic         ovf;
   } entry_t;

   entry_t          mem [DEPTH];
   entry_t          wr_entry;
   entry_t          head;
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CNTW-1:0] count;
   logic            push, pop, err_inc, ovf_inc;

   // Status is a pure function of the registered count, so no input reaches an output.
   assign o_count = count;
   assign o_full  = (count == CNTW'(DEPTH));
   assign o_empty = (count == '0);
   assign o_ready = !o_full;
   assign o_valid = !o_empty;

   assign push    = i_valid && !o_full;
   assign pop     = o_valid && i_ready;
   assign err_inc = push && i_err;
   assign ovf_inc = push && !i_err && i_ovf;

   always_comb begin
      wr_entry      = '0;
      wr_entry.err  = i_err;
      if (!i_err) begin
         wr_entry.ovf  = i_ovf;
         wr_entry.data = (i_data == NEG_ZERO) ? '0 : i_data;
      end
   end

   // Storage is deliberately left unreset; head outputs are masked while empty.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_entry;
   end

   assign head    = mem[rd_ptr];
   assign o_data  = o_empty ? '0 : head.data;
   assign o_err   = o_empty ? 1'b0 : head.err;
   assign o_ovf   = o_empty ? 1'b0 : head.ovf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CNTW'(1);
            2'b01:   count <= count - CNTW'(1);
            default: count <= count;
         endcase
      end
   end

   // i_clr takes priority over any same-cycle increment or drop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_err_cnt <= '0;
         o_ovf_cnt <= '0;
         o_drop    <= 1'b0;
      end else if (i_clr) begin
         o_err_cnt <= '0;
         o_ovf_cnt <= '0;
         o_drop    <= 1'b0;
      end else begin
         if (err_inc && (o_err_cnt != '1)) o_err_cnt <= o_err_cnt + CW'(1);
         if (ovf_inc && (o_ovf_cnt != '1)) o_ovf_cnt <= o_ovf_cnt + CW'(1);
         if (i_valid && o_full)            o_drop    <= 1'b1;
      end
   end
endmodule

// File: tb/tb_shift_result_fifo.sv
// Directed bench for shift_result_fifo; a CW=2 copy shares the stimulus to exercise saturation.
module tb_shift_result_fifo;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       i_valid = 1'b0, i_err = 1'b0, i_ovf = 1'b0, i_ready = 1'b0, i_clr = 1'b0;
   logic [7:0] i_data = '0;
   logic       o_ready, o_valid, o_err, o_ovf, o_full, o_empty, o_drop;
   logic [7:0] o_data, o_err_cnt, o_ovf_cnt;
   logic [2:0] o_count;
   logic       s_ready, s_valid, s_err, s_ovf, s_full, s_empty, s_drop;
   logic [7:0] s_data;
   logic [1:0] s_err_cnt, s_ovf_cnt;
   logic [2:0] s_count;
   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   shift_result_fifo #(.N(8), .DEPTH(4), .CW(8)) dut (
      .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
      .i_err(i_err), .i_ovf(i_ovf), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
      .o_err(o_err), .o_ovf(o_ovf), .o_count(o_count), .o_full(o_full), .o_empty(o_empty),
      .o_err_cnt(o_err_cnt), .o_ovf_cnt(o_ovf_cnt), .o_drop(o_drop), .i_clr(i_clr));

   shift_result_fifo #(.N(8), .DEPTH(4), .CW(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(s_ready), .i_data(i_data),
      .i_err(i_err), .i_ovf(i_ovf), .o_valid(s_valid), .i_ready(i_ready), .o_data(s_data),
      .o_err(s_err), .o_ovf(s_ovf), .o_count(s_count), .o_full(s_full), .o_empty(s_empty),
      .o_err_cnt(s_err_cnt), .o_ovf_cnt(s_ovf_cnt), .o_drop(s_drop), .i_clr(i_clr));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push1(input logic [7:0] d, input logic e, input logic v);
      i_valid = 1'b1; i_data = d; i_err = e; i_ovf = v;
      tick();
      i_valid = 1'b0; i_err = 1'b0; i_ovf = 1'b0;
   endtask

   task automatic test_reset;
      #3;
      checks++;
      if ({o_empty, o_full, o_ready, o_valid} !== 4'b1010) begin
         failures++; $display("FAIL reset_flags got=%b exp=1010", {o_empty, o_full, o_ready, o_valid});
      end
      checks++;
      if ({o_data, o_err, o_ovf, o_count, o_err_cnt, o_ovf_cnt, o_drop} !== '0) begin
         failures++; $display("FAIL reset_values data=%h cnt=%0d errc=%0d ovfc=%0d drop=%b",
                              o_data, o_count, o_err_cnt, o_ovf_cnt, o_drop);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_order;
      logic [7:0] exp [3];
      exp[0] = 8'h05; exp[1] = 8'h83; exp[2] = 8'h7F;
      push1(8'h05, 1'b0, 1'b0);
      checks++;
      if (o_valid !== 1'b1 || o_data !== 8'h05) begin
         failures++; $display("FAIL fwft_latency valid=%b data=%h exp=1/05", o_valid, o_data);
      end
      push1(8'h83, 1'b0, 1'b0);
      push1(8'h7F, 1'b0, 1'b0);
      checks++;
      if (o_count !== 3'd3 || o_data !== 8'h05) begin
         failures++; $display("FAIL order_fill count=%0d data=%h exp=3/05", o_count, o_data);
      end
      i_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (o_data !== exp[k]) begin
            failures++; $display("FAIL order_read%0d got=%h exp=%h", k, o_data, exp[k]);
         end
         tick();
      end
      i_ready = 1'b0;
      checks++;
      if (o_empty !== 1'b1 || o_data !== 8'h00) begin
         failures++; $display("FAIL order_empty empty=%b data=%h exp=1/00", o_empty, o_data);
      end
   endtask

   task automatic test_full_drop;
      for (int k = 1; k <= 5; k++) push1(8'h10 + 8'(k), 1'b0, 1'b0);
      checks++;
      if ({o_full, o_ready, o_drop, o_count} !== {3'b101, 3'd4}) begin
         failures++; $display("FAIL full_drop full=%b ready=%b drop=%b cnt=%0d exp=1 0 1 4",
                              o_full, o_ready, o_drop, o_count);
      end
      checks++;
      if (o_data !== 8'h11 || o_ovf_cnt !== 8'd0) begin
         failures++; $display("FAIL full_head data=%h ovfc=%0d exp=11/0", o_data, o_ovf_cnt);
      end
      i_clr = 1'b1; tick(); i_clr = 1'b0;
      checks++;
      if (o_drop !== 1'b0 || o_count !== 3'd4) begin
         failures++; $display("FAIL clr_drop drop=%b cnt=%0d exp=0/4", o_drop, o_count);
      end
   endtask

   task automatic test_back_to_back;
      // full: 11 12 13 14
      i_ready = 1'b1; i_valid = 1'b1; i_data = 8'h20;
      tick();
      i_valid = 1'b0;
      checks++;
      if (o_count !== 3'd3 || o_drop !== 1'b1 || o_data !== 8'h12) begin
         failures++; $display("FAIL full_pushpop cnt=%0d drop=%b data=%h exp=3/1/12", o_count, o_drop, o_data);
      end
      tick();
      i_valid = 1'b1; i_data = 8'h21;
      tick();
      checks++;
      if (o_count !== 3'd2 || o_data !== 8'h14) begin
         failures++; $display("FAIL pushpop_hold cnt=%0d data=%h exp=2/14", o_count, o_data);
      end
      i_data = 8'h22;
      tick();
      i_valid = 1'b0;
      checks++;
      if (o_count !== 3'd2 || o_data !== 8'h21) begin
         failures++; $display("FAIL wrap_head0 cnt=%0d data=%h exp=2/21", o_count, o_data);
      end
      tick();
      checks++;
      if (o_data !== 8'h22) begin
         failures++; $display("FAIL wrap_head1 got=%h exp=22", o_data);
      end
      tick();
      i_ready = 1'b0; i_clr = 1'b1; tick(); i_clr = 1'b0;
      checks++;
      if (o_empty !== 1'b1 || o_drop !== 1'b0) begin
         failures++; $display("FAIL wrap_drain empty=%b drop=%b exp=1/0", o_empty, o_drop);
      end
   endtask

   task automatic test_canon;
      push1(8'hAA, 1'b1, 1'b1);
      push1(8'h80, 1'b0, 1'b0);
      checks++;
      if (o_err_cnt !== 8'd1 || o_ovf_cnt !== 8'd0) begin
         failures++; $display("FAIL canon_cnt errc=%0d ovfc=%0d exp=1/0", o_err_cnt, o_ovf_cnt);
      end
      checks++;
      if ({o_valid, o_data, o_err, o_ovf} !== {1'b1, 8'h00, 1'b1, 1'b0}) begin
         failures++; $display("FAIL canon_err valid=%b data=%h err=%b ovf=%b exp=1/00/1/0",
                              o_valid, o_data, o_err, o_ovf);
      end
      i_ready = 1'b1; tick();
      checks++;
      if ({o_valid, o_data, o_err, o_ovf} !== {1'b1, 8'h00, 1'b0, 1'b0}) begin
         failures++; $display("FAIL canon_negzero valid=%b data=%h err=%b ovf=%b exp=1/00/0/0",
                              o_valid, o_data, o_err, o_ovf);
      end
      tick(); i_ready = 1'b0;
   endtask

   task automatic test_saturate;
      i_clr = 1'b1; tick(); i_clr = 1'b0;
      i_ready = 1'b1;
      for (int k = 0; k < 5; k++) push1(8'h01, 1'b0, 1'b1);
      checks++;
      if (s_ovf_cnt !== 2'd3 || o_ovf_cnt !== 8'd5) begin
         failures++; $display("FAIL ovf_sat sat=%0d wide=%0d exp=3/5", s_ovf_cnt, o_ovf_cnt);
      end
      i_clr = 1'b1;
      push1(8'h01, 1'b0, 1'b1);
      i_clr = 1'b0;
      checks++;
      if (s_ovf_cnt !== 2'd0 || o_ovf_cnt !== 8'd0 || o_count !== 3'd1) begin
         failures++; $display("FAIL clr_wins sat=%0d wide=%0d cnt=%0d exp=0/0/1", s_ovf_cnt, o_ovf_cnt, o_count);
      end
      tick(); i_ready = 1'b0;
   endtask

   task automatic test_async_reset;
      push1(8'h33, 1'b0, 1'b0);
      push1(8'h44, 1'b1, 1'b0);
      push1(8'h55, 1'b0, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({o_empty, o_valid, o_ready, o_full} !== 4'b1010 || o_data !== 8'h00) begin
         failures++; $display("FAIL async_rst_flags e/v/r/f=%b data=%h exp=1010/00",
                              {o_empty, o_valid, o_ready, o_full}, o_data);
      end
      checks++;
      if (o_err_cnt !== 8'd0 || o_ovf_cnt !== 8'd0 || o_count !== 3'd0) begin
         failures++; $display("FAIL async_rst_cnt errc=%0d ovfc=%0d cnt=%0d exp=0", o_err_cnt, o_ovf_cnt, o_count);
      end
      #2 rst_n = 1'b1;
      tick();
      checks++;
      if (o_empty !== 1'b1) begin
         failures++; $display("FAIL async_rst_post empty=%b exp=1", o_empty);
      end
   endtask

   initial begin
      test_reset();
      test_order();
      test_full_drop();
      test_back_to_back();
      test_canon();
      test_saturate();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
